// File: rtl/msrh_lsu_pkg.sv
// Shared L1<->L2 request/response payload types and requester index constants.
package msrh_lsu_pkg;

   localparam int L2_CMD_TAG_W = 8;

   localparam int L2_REQ_ID_IC = 0;
   localparam int L2_REQ_ID_DC = 1;

   typedef enum logic [1:0] {
      L2_CMD_RD_MISS = 2'd0,
      L2_CMD_WR_BACK = 2'd1,
      L2_CMD_PREF    = 2'd2,
      L2_CMD_RSVD    = 2'd3
   } l2_cmd_t;

   typedef struct packed {
      l2_cmd_t                  cmd;
      logic [31:0]              addr;
      logic [L2_CMD_TAG_W-1:0]  tag;
      logic [63:0]              data;
      logic [7:0]               byte_en;
   } l2_req_payload_t;

   typedef struct packed {
      logic [L2_CMD_TAG_W-1:0]  tag;
      logic [63:0]              data;
   } l2_resp_payload_t;

endpackage

// File: rtl/msrh_rr_arbiter.sv
// N-way round-robin picker: first requester at or after the pointer wins;
// the pointer moves past the winner only when the caller reports an accept.
module msrh_rr_arbiter #(
   parameter int N     = 2,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [N-1:0]     i_req,
   input  logic             i_advance,
   output logic [N-1:0]     o_grant,
   output logic [IDX_W-1:0] o_grant_idx
);

   logic [IDX_W-1:0] ptr_reg;
   logic [IDX_W-1:0] ptr_next;
   logic [IDX_W:0]   scan_idx;
   logic             found;

   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      found       = 1'b0;
      scan_idx    = '0;
      for (int off = 0; off < N; off++) begin
         scan_idx = {1'b0, ptr_reg} + (IDX_W+1)'(off);
         if (scan_idx >= (IDX_W+1)'(N)) begin
            scan_idx = scan_idx - (IDX_W+1)'(N);
         end
         if (!found && i_req[scan_idx[IDX_W-1:0]]) begin
            found                            = 1'b1;
            o_grant[scan_idx[IDX_W-1:0]]     = 1'b1;
            o_grant_idx                      = scan_idx[IDX_W-1:0];
         end
      end
   end

   assign ptr_next = (o_grant_idx == IDX_W'(N-1)) ? '0 : o_grant_idx + IDX_W'(1);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         ptr_reg <= '0;
      end else if (i_advance) begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/msrh_l2_req_arb.sv
// Shares the L2 request/response port among L1 requesters with per-requester credits.
// Define MSRH_L2_ARB_PERF_EN to add per-requester grant/stall performance counters.
module msrh_l2_req_arb
   import msrh_lsu_pkg::*;
#(
   parameter int REQ_N      = 2,
   parameter int MAX_OUTSTD = 4,
   parameter int ID_W       = $clog2(REQ_N)
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic [REQ_N-1:0]              i_req_valid,
   output logic [REQ_N-1:0]              o_req_ready,
   input  l2_req_payload_t [REQ_N-1:0]   i_req_payload,
   output logic                          o_l2_req_valid,
   input  logic                          i_l2_req_ready,
   output l2_req_payload_t               o_l2_req_payload,
   input  logic                          i_l2_resp_valid,
   output logic                          o_l2_resp_ready,
   input  l2_resp_payload_t              i_l2_resp_payload,
   output logic [REQ_N-1:0]              o_resp_valid,
   input  logic [REQ_N-1:0]              i_resp_ready,
`ifdef MSRH_L2_ARB_PERF_EN
   output logic [REQ_N-1:0][31:0]        o_perf_grant_cnt,
   output logic [REQ_N-1:0][31:0]        o_perf_stall_cnt,
`endif
   output l2_resp_payload_t              o_resp_payload
);

   localparam int CNT_W = $clog2(MAX_OUTSTD + 1);

   logic                        l2_req_valid_reg;
   l2_req_payload_t             l2_req_payload_reg;
   logic [REQ_N-1:0][CNT_W-1:0] cnt_reg;
   logic [REQ_N-1:0]            eligible;
   logic [REQ_N-1:0]            grant;
   logic [REQ_N-1:0]            req_fire;
   logic [REQ_N-1:0]            resp_sel;
   logic [REQ_N-1:0]            resp_fire;
   logic [ID_W-1:0]             grant_idx;
   logic [ID_W-1:0]             resp_id;
   logic                        slot_free;
   logic                        fire;
   logic                        resp_id_ok;
   l2_req_payload_t             winner_payload;

   assign slot_free = !l2_req_valid_reg | i_l2_req_ready;

   genvar gi;
   generate
      for (gi = 0; gi < REQ_N; gi++) begin : g_req
         assign eligible[gi] = i_req_valid[gi] & (cnt_reg[gi] < CNT_W'(MAX_OUTSTD));
         assign resp_sel[gi] = resp_id_ok & (resp_id == ID_W'(gi));
      end
   endgenerate

   msrh_rr_arbiter #(
      .N     (REQ_N),
      .IDX_W (ID_W)
   ) u_arb (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_req       (eligible),
      .i_advance   (fire),
      .o_grant     (grant),
      .o_grant_idx (grant_idx)
   );

   // Reset only masks the visible handshake; all state is already cleared asynchronously.
   assign req_fire    = grant & {REQ_N{slot_free}};
   assign fire        = |req_fire;
   assign o_req_ready = req_fire & {REQ_N{!i_reset}};

   always_comb begin
      winner_payload = i_req_payload[grant_idx];
      winner_payload.tag[L2_CMD_TAG_W-1 -: ID_W] = grant_idx;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         l2_req_valid_reg   <= 1'b0;
         l2_req_payload_reg <= '0;
      end else if (fire) begin
         l2_req_valid_reg   <= 1'b1;
         l2_req_payload_reg <= winner_payload;
      end else if (i_l2_req_ready) begin
         l2_req_valid_reg   <= 1'b0;
      end
   end

   assign o_l2_req_valid   = l2_req_valid_reg;
   assign o_l2_req_payload = l2_req_payload_reg;

   // Unknown IDs are swallowed so a stray response can never wedge the L2 port.
   assign resp_id         = i_l2_resp_payload.tag[L2_CMD_TAG_W-1 -: ID_W];
   assign resp_id_ok      = ({1'b0, resp_id} < (ID_W+1)'(REQ_N));
   assign o_resp_valid    = resp_sel & {REQ_N{i_l2_resp_valid}};
   assign resp_fire       = o_resp_valid & i_resp_ready;
   assign o_l2_resp_ready = resp_id_ok ? |(resp_sel & i_resp_ready) : 1'b1;
   assign o_resp_payload  = i_l2_resp_payload;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt_reg <= '0;
      end else begin
         for (int i = 0; i < REQ_N; i++) begin
            if (req_fire[i] && !resp_fire[i]) begin
               cnt_reg[i] <= cnt_reg[i] + CNT_W'(1);
            end else if (!req_fire[i] && resp_fire[i] && (cnt_reg[i] != '0)) begin
               cnt_reg[i] <= cnt_reg[i] - CNT_W'(1);
            end
         end
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (!i_reset) begin
         for (int i = 0; i < REQ_N; i++) begin
            assert (!(resp_fire[i] && !req_fire[i] && (cnt_reg[i] == '0)))
               else $error("msrh_l2_req_arb: response for requester %0d with zero outstanding", i);
         end
         assert (!(i_l2_resp_valid && !resp_id_ok))
            else $error("msrh_l2_req_arb: response id %0d out of range", resp_id);
      end
   end
`endif

`ifdef MSRH_L2_ARB_PERF_EN
   logic [REQ_N-1:0][31:0] perf_grant_reg;
   logic [REQ_N-1:0][31:0] perf_stall_reg;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         perf_grant_reg <= '0;
         perf_stall_reg <= '0;
      end else begin
         for (int i = 0; i < REQ_N; i++) begin
            if (req_fire[i] && (perf_grant_reg[i] != '1)) begin
               perf_grant_reg[i] <= perf_grant_reg[i] + 32'd1;
            end
            if (i_req_valid[i] && !req_fire[i] && (perf_stall_reg[i] != '1)) begin
               perf_stall_reg[i] <= perf_stall_reg[i] + 32'd1;
            end
         end
      end
   end

   assign o_perf_grant_cnt = perf_grant_reg;
   assign o_perf_stall_cnt = perf_stall_reg;
`endif

endmodule

// File: doc/msrh_l2_req_arb.md
Name: msrh_l2_req_arb

Overview:
- Shares the single L2 request/response port between REQ_N L1 requesters (requester 0 = ICache refill, 1 = DCache/LSU miss).
- Round-robin arbitration into a registered request slot. Per-requester outstanding-credit limit.
- Requester ID is stamped into the upper L2 tag bits; responses are routed back by those bits.
- Sits between the L1 miss engines and the L2 interface.

Parameters:
- REQ_N, 2, number of requesters (≥2).
- MAX_OUTSTD, 4, maximum in-flight requests per requester.
- ID_W, $clog2(REQ_N), width of the upper tag field carrying the requester ID.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_req_valid  in  REQ_N  per-requester request valid.
- o_req_ready  out  REQ_N  per-requester request accept.
- i_req_payload  in  REQ_N x l2_req_payload_t  cmd/addr/tag/data/byte_en per requester.
- o_l2_req_valid  out  1  L2 request valid.
- i_l2_req_ready  in  1  L2 accept.
- o_l2_req_payload  out  l2_req_payload_t  registered winner payload.
- i_l2_resp_valid  in  1  L2 response valid.
- o_l2_resp_ready  out  1  L2 response accept.
- i_l2_resp_payload  in  l2_resp_payload_t  tag/data.
- o_resp_valid  out  REQ_N  routed response valid, one-hot.
- i_resp_ready  in  REQ_N  requester response accept.
- o_resp_payload  out  l2_resp_payload_t  broadcast to all requesters.

Behaviour:
- Reset values: o_l2_req_valid=0, o_l2_req_payload=0, RR pointer=0, all outstanding counts=0, o_req_ready=0 while reset is asserted.
- Slot free = !o_l2_req_valid | i_l2_req_ready.
- Eligibility: requester i is eligible when i_req_valid[i] & (cnt[i] < MAX_OUTSTD).
- Grant: the eligible requester first at or after the RR pointer, searching upward with wrap.
- o_req_ready[i] = slot free & grant[i]. o_req_ready is combinational, at most one bit high.
- Accept (fire): next cycle o_l2_req_valid=1 and payload = winner's payload with tag[L2_CMD_TAG_W-1 -: ID_W] replaced by the winner index. Zero-cycle bubble when the slot drains in the same cycle.
- RR pointer becomes winner+1 (mod REQ_N) on accept only.
- Hold rule: while o_l2_req_valid & !i_l2_req_ready, payload and valid are held stable.
- Counting:
  - cnt[i] increments on accept of requester i.
  - cnt[i] decrements on response fire with ID==i.
  - Both in the same cycle: unchanged.
  - Never wraps; an assertion fires on decrement at 0.
- Response routing: id = i_l2_resp_payload.tag upper ID_W bits.
  - o_resp_valid[id] = i_l2_resp_valid.
  - o_l2_resp_ready = i_resp_ready[id].
  - Response path is purely combinational.
- Out-of-range id (≥REQ_N): response is consumed (ready=1) and dropped, no count change. Simulation assertion error.
- Fixed latency: accept to o_l2_req_valid is 1 cycle.
- Reset asserted mid-transaction: slot and counts clear immediately. In-flight L2 responses arriving after reset are still routed; their count decrement saturates at 0.

Optional Feature:
- Macro MSRH_L2_ARB_PERF_EN.
- Defined: adds outputs o_perf_grant_cnt[REQ_N] (32b each) and o_perf_stall_cnt[REQ_N] (32b each).
  - Grant count increments on accept.
  - Stall count increments when i_req_valid[i] & !o_req_ready[i].
  - Both saturate at 2^32-1 and reset to 0.
- Undefined: these ports and their counters are absent; the block is otherwise identical.

Decomposition:
- msrh_lsu_pkg holds l2_req_payload_t, l2_resp_payload_t, L2_CMD_TAG_W, and the requester index constants L2_REQ_ID_IC=0 and L2_REQ_ID_DC=1.
- One sub-module: msrh_rr_arbiter (REQ_N-wide round-robin pick with pointer, outputs one-hot grant), reused by other shared ports.

Test Plan:
- Both requesters valid every cycle, i_l2_req_ready=1 → grants alternate 0,1,0,1; tags carry ID 0/1 in the MSB; 1 request/cycle.
- Requester 0 issues 4 requests with no responses, MAX_OUTSTD=4 → 5th is blocked (o_req_ready[0]=0) while requester 1 is still granted; one ID-0 response → requester 0 is granted next cycle.
- i_l2_req_ready=0 for 3 cycles with a pending request (addr 0x8000_0040) → payload held bit-exact, o_req_ready=0 for all, accept resumes on the ready cycle.
- Response with tag ID=1 and i_resp_ready[1]=0 → o_resp_valid=2'b10, o_l2_resp_ready=0 until ready goes high; cnt[1] decrements on that fire only.
- Same-cycle accept and response for requester 0 at cnt=2 → cnt stays 2.
- Reset pulsed with o_l2_req_valid=1 and cnt={3,1} → next cycle valid=0, counts 0, RR pointer 0.
